// File: rtl/regfile_pkg.sv
// Shared widths, payload type and lookup helper for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(0);

    typedef struct packed {
        logic [ADDR_W-1:0] pos;
        logic [DATA_W-1:0] value;
    } wr_req_t;

    // Returns {hit, value} for a query against the two holding slots; younger slot wins a double match.
    function automatic logic [DATA_W:0] slot_lookup(
        input logic [ADDR_W-1:0] q,
        input logic              f0,
        input wr_req_t           s0,
        input logic              f1,
        input wr_req_t           s1,
        input logic              s1_older
    );
        logic m0;
        logic m1;
        m0 = f0 && (s0.pos == q) && (q != REG_ZERO);
        m1 = f1 && (s1.pos == q) && (q != REG_ZERO);
        if (m0 && m1)
            return {1'b1, (s1_older ? s0.value : s1.value)};
        else if (m0)
            return {1'b1, s0.value};
        else if (m1)
            return {1'b1, s1.value};
        return '0;
    endfunction

endpackage

// File: rtl/wr_slot.sv
// One-entry holding register for a pending register-file write; load has priority over free.
module wr_slot
    import regfile_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    load,
    input  logic    free,
    input  wr_req_t din,
    output logic    full,
    output wr_req_t dout
);

    always_ff @(posedge clock) begin
        if (reset) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (free) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
// Optional WR_FORWARD_EN adds two combinational lookup ports into the pending slots.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_pos,
    input  logic [DATA_W-1:0] req0_value,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_pos,
    input  logic [DATA_W-1:0] req1_value,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_pos,
    output logic [DATA_W-1:0] wr_value,
    output logic              busy
`ifdef WR_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0] q_pos1,
    input  logic [ADDR_W-1:0] q_pos2,
    output logic              q_hit1,
    output logic              q_hit2,
    output logic [DATA_W-1:0] q_value1,
    output logic [DATA_W-1:0] q_value2
`endif
);

    logic    full0;
    logic    full1;
    wr_req_t slot0;
    wr_req_t slot1;
    wr_req_t in0;
    wr_req_t in1;
    wr_req_t sel;
    logic    acc0;
    logic    acc1;
    logic    gnt0;
    logic    gnt1;
    logic    both;
    logic    same;

    // rr_ptr=0 favours req0; age1_older=1 means slot1 filled before slot0
    logic    rr_ptr;
    logic    rr_next;
    logic    age1_older;
    logic    age_next;

    assign in0 = '{pos: req0_pos, value: req0_value};
    assign in1 = '{pos: req1_pos, value: req1_value};

    wr_slot u_slot0 (
        .clock (clock),
        .reset (reset),
        .load  (acc0),
        .free  (gnt0),
        .din   (in0),
        .full  (full0),
        .dout  (slot0)
    );

    wr_slot u_slot1 (
        .clock (clock),
        .reset (reset),
        .load  (acc1),
        .free  (gnt1),
        .din   (in1),
        .full  (full1),
        .dout  (slot1)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= 1'b0;
            age1_older <= 1'b0;
        end else begin
            rr_ptr     <= rr_next;
            age1_older <= age_next;
        end
    end

    // Grant, handshake and write-port decode; age decides same-register conflicts
    always_comb begin
        both     = full0 && full1;
        same     = (slot0.pos == slot1.pos);
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        rr_next  = rr_ptr;
        age_next = age1_older;

        if (both) begin
            gnt1 = same ? age1_older : rr_ptr;
            gnt0 = !gnt1;
            if (!same)
                rr_next = gnt0;
        end else begin
            gnt0 = full0;
            gnt1 = full1;
        end

        req0_ready = !full0 || gnt0;
        req1_ready = !full1 || gnt1;
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;

        // Simultaneous fills leave slot0 older
        if (acc1)
            age_next = 1'b0;
        else if (acc0)
            age_next = 1'b1;

        sel      = gnt1 ? slot1 : slot0;
        wr_en    = (gnt0 || gnt1) && (sel.pos != REG_ZERO);
        wr_pos   = wr_en ? sel.pos : REG_ZERO;
        wr_value = wr_en ? sel.value : DATA_W'(0);
        busy     = full0 || full1;
    end

`ifdef WR_FORWARD_EN
    always_comb begin
        {q_hit1, q_value1} = slot_lookup(q_pos1, full0, slot0, full1, slot1, age1_older);
        {q_hit2, q_value2} = slot_lookup(q_pos2, full0, slot0, full1, slot1, age1_older);
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a slot/stamp reference model.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_pos;
    logic [31:0] req0_value;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_pos;
    logic [31:0] req1_value;
    logic        wr_en;
    logic [4:0]  wr_pos;
    logic [31:0] wr_value;
    logic        busy;
`ifdef WR_FORWARD_EN
    logic [4:0]  q_pos1;
    logic [4:0]  q_pos2;
    logic        q_hit1;
    logic        q_hit2;
    logic [31:0] q_value1;
    logic [31:0] q_value2;
`endif

    regfile_write_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_pos   (req0_pos),
        .req0_value (req0_value),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_pos   (req1_pos),
        .req1_value (req1_value),
        .wr_en      (wr_en),
        .wr_pos     (wr_pos),
        .wr_value   (wr_value),
        .busy       (busy)
`ifdef WR_FORWARD_EN
        ,
        .q_pos1     (q_pos1),
        .q_pos2     (q_pos2),
        .q_hit1     (q_hit1),
        .q_hit2     (q_hit2),
        .q_value1   (q_value1),
        .q_value2   (q_value2)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: each slot carries an arrival stamp; smaller stamp = older
    bit          m_full [2];
    logic [4:0]  m_pos  [2];
    logic [31:0] m_val  [2];
    int          m_stamp[2];
    int          stamp_ctr = 0;
    int          m_favour = 0;
    logic [31:0] m_rf [32];
    logic [31:0] d_rf [32];
    bit          last_a0;
    bit          last_a1;
    logic [4:0]  q1_sel = 5'd0;
    logic [4:0]  q2_sel = 5'd0;

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = 32'd0;
            d_rf[r] = 32'd0;
        end
    end

    // Register file as seen through the write port
    always @(posedge clock) begin
        if (reset === 1'b0 && wr_en === 1'b1)
            d_rf[wr_pos] <= wr_value;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (m_full[0] && m_full[1]) begin
            if (m_pos[0] == m_pos[1])
                return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
            return m_favour;
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    function automatic logic [32:0] model_query(input logic [4:0] q);
        bit h0;
        bit h1;
        h0 = m_full[0] && m_pos[0] == q && q != 5'd0;
        h1 = m_full[1] && m_pos[1] == q && q != 5'd0;
        if (h0 && h1) return {1'b1, (m_stamp[0] > m_stamp[1]) ? m_val[0] : m_val[1]};
        if (h0) return {1'b1, m_val[0]};
        if (h1) return {1'b1, m_val[1]};
        return 33'd0;
    endfunction

    // Advances the model across one posedge using the inputs currently driven
    task automatic model_step(output bit a0, output bit a1);
        int g;
        bit both;
        g    = model_grant();
        both = m_full[0] && m_full[1];
        a0   = 1'b0;
        a1   = 1'b0;
        if (reset) begin
            m_full[0] = 1'b0;
            m_full[1] = 1'b0;
            m_favour  = 0;
            return;
        end
        a0 = req0_valid && (!m_full[0] || g == 0);
        a1 = req1_valid && (!m_full[1] || g == 1);
        if (g >= 0) begin
            if (m_pos[g] != 5'd0) m_rf[m_pos[g]] = m_val[g];
            if (both && m_pos[0] != m_pos[1]) m_favour = 1 - g;
            m_full[g] = 1'b0;
        end
        if (a0) begin
            m_full[0] = 1'b1; m_pos[0] = req0_pos; m_val[0] = req0_value;
            m_stamp[0] = stamp_ctr++;
        end
        if (a1) begin
            m_full[1] = 1'b1; m_pos[1] = req1_pos; m_val[1] = req1_value;
            m_stamp[1] = stamp_ctr++;
        end
    endtask

    task automatic compare();
        int g;
        int gi;
        bit exp_en;
        g      = model_grant();
        gi     = (g < 0) ? 0 : g;
        exp_en = (g >= 0) && (m_pos[gi] != 5'd0);
        check("wr_en", wr_en, exp_en);
        check("wr_pos", wr_pos, exp_en ? m_pos[gi] : 5'd0);
        if (exp_en || g < 0)
            check("wr_value", wr_value, exp_en ? m_val[gi] : 32'd0);
        check("busy", busy, m_full[0] || m_full[1]);
        check("req0_ready", req0_ready, !m_full[0] || g == 0);
        check("req1_ready", req1_ready, !m_full[1] || g == 1);
`ifdef WR_FORWARD_EN
        check("q1", {q_hit1, q_value1}, model_query(q_pos1));
        check("q2", {q_hit2, q_value2}, model_query(q_pos2));
`endif
    endtask

    task automatic step(input bit rst,
                        input bit v0, input int p0, input logic [31:0] x0,
                        input bit v1, input int p1, input logic [31:0] x1);
        reset      = rst;
        req0_valid = v0;
        req0_pos   = 5'(p0);
        req0_value = x0;
        req1_valid = v1;
        req1_pos   = 5'(p1);
        req1_value = x1;
`ifdef WR_FORWARD_EN
        q_pos1 = q1_sel;
        q_pos2 = q2_sel;
`endif
        model_step(last_a0, last_a1);
        @(negedge clock);
        compare();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0);
    endtask

    function automatic int rand_pos();
        return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
    endfunction

    bit          rv0 = 1'b0;
    bit          rv1 = 1'b0;
    int          rp0 = 0;
    int          rp1 = 0;
    logic [31:0] rx0 = 32'd0;
    logic [31:0] rx1 = 32'd0;

    initial begin
        // Reset held with a request presented: nothing may load
        step(1'b1, 1'b1, 3, 32'h11, 1'b0, 0, 32'd0);
        step(1'b1, 1'b1, 3, 32'h11, 1'b0, 0, 32'd0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b11);
        idle();
        check("rst_noload", busy, 1'b0);

        // Single request: write one edge after accept
        step(1'b0, 1'b1, 3, 32'hA5, 1'b0, 0, 32'd0);
        check("single_en", wr_en, 1'b1);
        check("single_pos", wr_pos, 5'd3);
        check("single_val", wr_value, 32'hA5);
        idle();
        check("single_busy", busy, 1'b0);

        // Contention on different registers alternates 0,1,0,1
        step(1'b0, 1'b1, 4, 32'hA0, 1'b1, 7, 32'hB0);
        check("rr0", {wr_pos, wr_value}, {5'd4, 32'hA0});
        step(1'b0, 1'b1, 4, 32'hA1, 1'b0, 0, 32'd0);
        check("rr1", {wr_pos, wr_value}, {5'd7, 32'hB0});
        step(1'b0, 1'b0, 0, 32'd0, 1'b1, 7, 32'hB1);
        check("rr2", {wr_pos, wr_value}, {5'd4, 32'hA1});
        idle();
        check("rr3", {wr_pos, wr_value}, {5'd7, 32'hB1});
        idle();
        check("rr_idle", {wr_en, busy}, 2'b00);

        // Equal register with slot1 older while pointer favours req0
        step(1'b1, 1'b0, 0, 32'd0, 1'b0, 0, 32'd0);
        step(1'b0, 1'b1, 9, 32'd5, 1'b1, 9, 32'd11);
        check("eq0", {wr_pos, wr_value}, {5'd9, 32'd5});
        step(1'b0, 1'b1, 9, 32'd22, 1'b0, 0, 32'd0);
        check("eq1", {wr_pos, wr_value}, {5'd9, 32'd11});
        idle();
        check("eq2", {wr_pos, wr_value}, {5'd9, 32'd22});
        idle();
        check("eq_reg9", d_rf[9], 32'd22);

        // Register 0 occupies a slot but never writes
        step(1'b0, 1'b0, 0, 32'd0, 1'b1, 0, 32'hFFFF_FFFF);
        check("r0_en", wr_en, 1'b0);
        check("r0_pos", wr_pos, 5'd0);
        check("r0_busy", busy, 1'b1);
        idle();
        check("r0_free", busy, 1'b0);

`ifdef WR_FORWARD_EN
        // Double match returns the younger slot
        q1_sel = 5'd5;
        step(1'b0, 1'b1, 2, 32'd1, 1'b1, 3, 32'd2);
        step(1'b0, 1'b1, 5, 32'd50, 1'b0, 0, 32'd0);
        step(1'b0, 1'b0, 0, 32'd0, 1'b1, 5, 32'd60);
        check("fwd_hit", {q_hit1, q_value1}, {1'b1, 32'd60});
        idle();
        idle();
        idle();
        check("fwd_drained", q_hit1, 1'b0);
`endif

        // Random traffic with held-until-accepted requests and occasional reset
        last_a0 = 1'b0;
        last_a1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!(rv0 && !last_a0)) begin
                rv0 = ($urandom_range(0, 99) < 60);
                rp0 = rand_pos();
                rx0 = $urandom;
            end
            if (!(rv1 && !last_a1)) begin
                rv1 = ($urandom_range(0, 99) < 60);
                rp1 = rand_pos();
                rx1 = $urandom;
            end
            q1_sel = 5'($urandom_range(0, 3));
            q2_sel = 5'($urandom_range(0, 31));
            step($urandom_range(0, 199) == 0, rv0, rp0, rx0, rv1, rp1, rx1);
        end
        idle();
        idle();
        idle();
        for (int r = 0; r < 32; r++)
            check($sformatf("rf%0d", r), d_rf[r], m_rf[r]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: req0 (ALU result) and req1 (load/memory result). Each requester has a one-entry holding slot behind a valid/ready handshake. A round-robin arbiter drains the slots into the register-file write port, keeping same-register writes in order. Sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register index (32 registers; register 0 hardwired to zero)

Ports:
clock  input  1  single clock, all state updates on posedge
reset  input  1  synchronous, active-high
req0_valid  input  1  ALU write request
req0_ready  output  1  slot0 can accept this cycle
req0_pos  input  ADDR_W  ALU destination register
req0_value  input  DATA_W  ALU write data
req1_valid  input  1  memory write request
req1_ready  output  1  slot1 can accept this cycle
req1_pos  input  ADDR_W  memory destination register
req1_value  input  DATA_W  memory write data
wr_en  output  1  register-file write qualifier
wr_pos  output  ADDR_W  register-file write index
wr_value  output  DATA_W  register-file write data
busy  output  1  either slot occupied

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset: both slots empty; age flag cleared; round-robin pointer set to favour req0. The outputs follow from this state: wr_en=0, wr_pos=0, wr_value=0, busy=0, req0_ready=1, req1_ready=1.
- Accept: reqN is accepted at a posedge when reqN_valid=1 and reqN_ready=1. The accept loads slotN with {pos, value}.
- reqN_ready = slotN empty OR slotN granted this cycle, so one request per slot per cycle is sustained.
- Grant: combinational from slot state. The granted slot drives wr_en=1, wr_pos and wr_value. The register file samples them at the next posedge, and the slot frees at that same edge.
- Latency: accept at edge N, write at edge N+1 minimum.
- Arbitration with one slot full: grant that slot.
- Arbitration with both slots full and different pos: round-robin. The pointer toggles to the other requester after every grant taken while both slots were full.
- Arbitration with both slots full and equal pos: grant the older slot, regardless of the pointer. The pointer is unchanged.
- Age flag: records which slot filled first.
  - Simultaneous fill into two empty slots: slot0 is older.
  - Refill while the other slot is held: the refilled slot is younger.
- Register 0: a request with pos=0 is accepted and occupies its slot. When granted, it drives wr_en=0, wr_pos=0, and the slot frees. No visible write occurs.
- Idle (no grant): wr_en=0, wr_pos=0, wr_value=0. Write data always goes to register 0, so an unqualified register-file write is harmless.
- Valid held with ready low: the requester must hold valid, pos and value stable until accepted. The arbiter never drops a presented request.
- Reset mid-operation: any occupied slots are discarded without writing. Outputs take their reset values in the cycle after the reset edge.
- busy = slot0 full OR slot1 full.

Optional Feature:
WR_FORWARD_EN
- Defined: adds query ports q_pos1, q_pos2 (input ADDR_W) and outputs q_hit1, q_hit2 (1) and q_value1, q_value2 (DATA_W).
- q_hitK=1 when an occupied slot holds pos==q_posK and q_posK!=0. q_valueK is that slot's data.
  - If both slots match, the younger slot's data is returned.
  - Otherwise q_hitK=0 and q_valueK=0.
- The query is purely combinational from slot state and does not include same-cycle incoming requests.
- Not defined: query ports are absent; all other behaviour is identical.

Decomposition:
- Shared package regfile_pkg holds: DATA_W and ADDR_W defaults; REG_ZERO constant (0); the write-request struct typedef {pos, value}.
- One sub-module, wr_slot: a one-entry holding register with full flag, load and free inputs. It is instantiated twice.
- Arbitration, age tracking and forwarding live in the top module.

Test Plan:
- Reset: assert reset for 2 cycles with req0_valid=1 → wr_en=0, busy=0, both ready=1. No slot loaded until reset is released.
- Single: req0 {pos=3, value=32'hA5} accepted at edge N → at edge N+1 wr_en=1, wr_pos=3, wr_value=A5. busy=0 after that edge.
- Contention, different pos: both slots full (req0 pos=4, req1 pos=7) for 4 consecutive accepts → grants alternate 0,1,0,1 and each request is written exactly once.
- Contention, equal pos: slot1 {pos=9, 11} loaded one cycle before slot0 {pos=9, 22} → write of 11 precedes write of 22; final register 9 = 22.
- Register 0: req1 {pos=0, value=FFFFFFFF} → accepted, wr_en stays 0, wr_pos=0, slot frees one cycle later.
- With WR_FORWARD_EN: slot0 {pos=5, 50}, then slot1 {pos=5, 60}, q_pos1=5 → q_hit1=1, q_value1=60. After both drain, q_hit1=0.
